// File: rtl/enc_edge_stamper.sv
// Encoder edge stamper: synchronizes and deglitches enc_in, stamps each
// accepted edge with a 48-bit cycle count and a 15-bit sequence number,
// buffers the events and presents them as an AXI4-Stream master.
// Event word layout: {pol, seq[14:0], ts[47:0]}.
module enc_edge_stamper #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILT_LEN    = 4,
  parameter int unsigned FIFO_DEPTH  = 16
) (
  input  logic                          aclk,
  input  logic                          aresetn,
  input  logic                          enc_in,
  input  logic                          en,
  input  logic                          clr,
  output logic [63:0]                   m_axis_tdata,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [15:0]                   overflow_cnt
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam logic [7:0]  FCNT_LAST = 8'(FILT_LEN - 1);

  // Front end: synchronizer, glitch filter, timestamp, event register
  logic [SYNC_STAGES-1:0] sync_chain_q, sync_chain_d;
  logic                   sync_q;
  logic                   filt_q, filt_d;
  logic [7:0]             fcnt_q, fcnt_d;
  logic [47:0]            ts_q, ts_d;
  logic [14:0]            seq_q, seq_d;
  logic                   evt_vld_q, evt_vld_d;
  logic [63:0]            evt_data_q, evt_data_d;
  logic                   evt_fire;

  // Buffer: storage array plus first-word-fall-through output register.
  // The output register is filled from the array when it has entries, or
  // directly from the event register when the array is empty, so the array
  // never holds more than FIFO_DEPTH-1 words.
  logic [63:0]            mem [FIFO_DEPTH];
  logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]          mem_cnt_q, mem_cnt_d;
  logic                   out_vld_q, out_vld_d;
  logic [63:0]            out_data_q, out_data_d;
  logic [15:0]            ovf_q, ovf_d;

  logic                   pop, has_room, push, drop, out_free;
  logic                   mem_rd, mem_we, bypass;
  logic [LW-1:0]          level;

  assign sync_q = sync_chain_q[SYNC_STAGES-1];
  assign level  = mem_cnt_q + LW'(out_vld_q);

  // Next-state logic for the synchronizer, filter, timestamp and event capture
  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch is inferred.
    sync_chain_d = {sync_chain_q[SYNC_STAGES-2:0], enc_in};
    filt_d       = filt_q;
    fcnt_d       = '0;
    if (sync_q != filt_q) begin
      if (fcnt_q == FCNT_LAST) begin
        filt_d = sync_q;
      end else begin
        fcnt_d = fcnt_q + 8'd1;
      end
    end
    // An edge is the cycle the filtered level flips; clr suppresses it.
    evt_fire   = (filt_d != filt_q) && en && !clr;
    ts_d       = ts_q + 48'd1;
    seq_d      = evt_fire ? seq_q + 15'd1 : seq_q;
    evt_vld_d  = evt_fire;
    evt_data_d = evt_fire ? {filt_d, seq_q, ts_q} : evt_data_q;
    if (clr) begin
      ts_d       = '0;
      seq_d      = '0;
      fcnt_d     = '0;
      evt_data_d = '0;
    end
  end

  // Next-state logic for the event buffer, output register and drop counter
  always_comb begin
    pop      = out_vld_q && m_axis_tready;
    has_room = (level < LW'(FIFO_DEPTH)) || pop;
    push     = evt_vld_q && has_room && !clr;
    drop     = evt_vld_q && !has_room && !clr;
    out_free = !out_vld_q || pop;
    mem_rd   = out_free && (mem_cnt_q != '0);
    bypass   = push && out_free && (mem_cnt_q == '0);
    mem_we   = push && !bypass;

    out_vld_d  = out_vld_q;
    out_data_d = out_data_q;
    if (out_free) begin
      if (mem_rd) begin
        out_vld_d  = 1'b1;
        out_data_d = mem[rd_ptr_q];
      end else if (bypass) begin
        out_vld_d  = 1'b1;
        out_data_d = evt_data_q;
      end else begin
        out_vld_d  = 1'b0;
      end
    end

    wr_ptr_d  = wr_ptr_q + AW'(mem_we);
    rd_ptr_d  = rd_ptr_q + AW'(mem_rd);
    mem_cnt_d = mem_cnt_q + LW'(mem_we) - LW'(mem_rd);

    ovf_d = ovf_q;
    if (drop && (ovf_q != 16'hFFFF)) begin
      ovf_d = ovf_q + 16'd1;
    end

    if (clr) begin
      out_vld_d  = 1'b0;
      out_data_d = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      mem_cnt_d  = '0;
      ovf_d      = '0;
    end
  end

  // State registers with asynchronous clear
  always_ff @(posedge aclk or negedge aresetn) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (!aresetn) begin
      sync_chain_q <= '0;
      filt_q       <= 1'b0;
      fcnt_q       <= '0;
      ts_q         <= '0;
      seq_q        <= '0;
      evt_vld_q    <= 1'b0;
      evt_data_q   <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      mem_cnt_q    <= '0;
      out_vld_q    <= 1'b0;
      out_data_q   <= '0;
      ovf_q        <= '0;
    end else begin
      sync_chain_q <= sync_chain_d;
      filt_q       <= filt_d;
      fcnt_q       <= fcnt_d;
      ts_q         <= ts_d;
      seq_q        <= seq_d;
      evt_vld_q    <= evt_vld_d;
      evt_data_q   <= evt_data_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      mem_cnt_q    <= mem_cnt_d;
      out_vld_q    <= out_vld_d;
      out_data_q   <= out_data_d;
      ovf_q        <= ovf_d;
    end
  end

  // Event storage array written from the event register
  always_ff @(posedge aclk) begin
    // NOTE: the array is not reset; pointers and count define which entries are valid.
    if (mem_we) begin
      mem[wr_ptr_q] <= evt_data_q;
    end
  end

  assign m_axis_tdata  = out_data_q;
  assign m_axis_tvalid = out_vld_q;
  assign fifo_level    = level;
  assign overflow_cnt  = ovf_q;

endmodule
